multiplier: RTL and testbench
=============================

MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 SHALL have port mul_clk  input  1  sole block clock; all state changes on rising edge.
REQ-002 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port mul  input  1  start request; level-sensitive; sampled only in IDLE.
REQ-004 SHALL have port mul_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with mul.
REQ-005 SHALL have port x  input  32  multiplicand; sampled with mul.
REQ-006 SHALL have port y  input  32  multiplier; sampled with mul.
REQ-007 SHALL have port result  output  64  product; signed or unsigned per sampled mul_signed.
REQ-008 SHALL have port complete  output  1  high for exactly one cycle when result is valid.
REQ-009 SHALL have port busy  output  1  high in every non-IDLE state.

Function
REQ-010 SHALL implement states IDLE, RUN, FIX, DONE, registered.
REQ-011 IDLE with mul=1 SHALL accept at that edge: latch |x|, |y|, result sign, clear accumulator and iteration counter, then enter RUN.
- Magnitudes SHALL be taken only when mul_signed=1 and the operand bit 31 is set; otherwise the raw value is used.
REQ-012 Result sign SHALL be x[31]^y[31] when mul_signed=1, else 0.
REQ-013 Each RUN edge SHALL perform one radix-2 shift-add step.
- If multiplier-register bit 0 is 1, add the 64-bit multiplicand register to the 64-bit accumulator.
- Shift the multiplicand register left 1 and the multiplier register right 1.
- Increment the counter.
REQ-014 RUN SHALL perform exactly 32 iterations, then go to FIX.
REQ-015 The FIX edge SHALL write result as the two's-complement negation of the accumulator if the result sign is 1, else the accumulator, then enter DONE.
REQ-016 complete SHALL be 1 only in DONE; DONE SHALL return to IDLE at the next edge.
REQ-017 Latency without the option: accept edge E0, complete high in the cycle following E33.
REQ-018 Back-to-back operation SHALL be supported.
- mul held high continuously starts a new operation in the first IDLE cycle after DONE.
- mul asserted in RUN, FIX or DONE SHALL be ignored.
REQ-019 result SHALL hold its last value from the FIX edge until the next FIX edge; it SHALL NOT change during RUN.
REQ-020 Operand inputs SHALL NOT affect an operation after its accept edge.
REQ-021 Arithmetic SHALL be exact for all 2^64 operand pairs in both modes.
- Signed 0x80000000 * 0x80000000 = 0x4000000000000000.
- Unsigned 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE00000001.

Reset
REQ-022 resetn=0 at an edge SHALL force IDLE; result=0, complete=0, busy=0, counter=0, internal registers=0.
REQ-023 Reset SHALL take priority over every transition, including mid-RUN and in DONE; the aborted operation SHALL NOT assert complete.
REQ-024 mul high in the same cycle as resetn=0 SHALL NOT be accepted.

Configuration
REQ-025 Macro MUL_EARLY_TERM_EN SHALL control early termination.
- Defined: a RUN edge whose multiplier register is already 0 SHALL perform no add and go directly to FIX.
- Not defined: RUN always performs exactly 32 iterations (REQ-014); latency is fixed at REQ-017.
REQ-026 Results SHALL be identical with and without MUL_EARLY_TERM_EN; only latency differs.
- With the macro defined: y=0 gives complete after E2; |y|=1 gives complete after E3.

Structure
REQ-027 Shared package mul_pkg SHALL hold the operand width (32), product width (64), iteration count (32) and state encoding type.
REQ-028 Conditional two's-complement SHALL be one sub-module, abs_conv, instanced for x, y and the FIX negation (parameterised width).

Verification
REQ-029 Unsigned: x=0xFFFFFFFF, y=0xFFFFFFFF, mul_signed=0 -> result=0xFFFFFFFE00000001; complete one cycle, 33 edges after accept (macro off).
REQ-030 Signed: x=0xFFFFFFFD (-3), y=7, mul_signed=1 -> result=0xFFFFFFFFFFFFFFEB (-21); the same operands with mul_signed=0 -> 0x00000006FFFFFFEB.
REQ-031 Corner: x=y=0x80000000, mul_signed=1 -> result=0x4000000000000000.
REQ-032 Reset mid-run: resetn=0 for one cycle at counter 10 -> complete never asserted, result=0, busy=0; a following mul x=2, y=3 -> result=6.
REQ-033 Back-to-back: mul held high with x=5, y=6, then x=7, y=8 applied after the first complete -> result 30 then 56; busy low for exactly one cycle between the two operations.
REQ-034 MUL_EARLY_TERM_EN: y=0 -> complete after E2, result 0; y=1, x=9 -> complete after E3, result 9; y=0x80000000, mul_signed=0 -> 33-edge latency.

Source files
------------

// File: rtl/mul_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared constants and state encoding for the iterative 32x32 multiplier.
//   OP_W    : operand width (32)
//   PROD_W  : product width (64)
//   ITERS   : number of radix-2 shift-add iterations (32)
//   CNT_W   : width of the iteration counter
//   mul_state_e : FSM state encoding (IDLE, RUN, FIX, DONE)
// ----------------------------------------------------------------------------
package mul_pkg;

  localparam int unsigned OP_W   = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  // True when the counter value marks the final shift-add iteration.
  function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(ITERS - 1));
  endfunction

endpackage

// File: rtl/abs_conv.sv
// ----------------------------------------------------------------------------
// abs_conv
// Conditional two's-complement negation of a W-bit value. Used to take operand
// magnitudes and to apply the product sign.
//   i_val [W-1:0] : input value
//   i_neg         : 1 = output the two's-complement negation, 0 = pass through
//   o_val [W-1:0] : converted value
// ----------------------------------------------------------------------------
module abs_conv #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negate when requested; the most negative value maps onto itself, which
  // is the correct unsigned magnitude.
  always_comb begin
    if (i_neg) begin
      o_val = (~i_val) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      o_val = i_val;
    end
  end

endmodule

// File: rtl/multiplier.sv
// ----------------------------------------------------------------------------
// multiplier
// Iterative radix-2 shift-add 32x32 -> 64 multiplier, signed or unsigned.
// Operands are converted to magnitudes at accept, multiplied over 32 RUN
// cycles, and the sign is applied in a single FIX cycle.
//
// Ports:
//   mul_clk     : block clock, rising edge
//   resetn      : synchronous active-low reset
//   mul         : start request, level-sensitive, sampled only in IDLE
//   mul_signed  : 1 = two's-complement operands, sampled with mul
//   x, y [31:0] : multiplicand / multiplier, sampled with mul
//   result[63:0]: product, updated only at the FIX edge
//   complete    : one-cycle pulse while result is newly valid (DONE state)
//   busy        : high in every non-IDLE state
//
// Configuration macro:
//   MUL_EARLY_TERM_EN : when defined, RUN exits to FIX as soon as the
//                       multiplier register has no remaining set bits.
// ----------------------------------------------------------------------------
module multiplier
  import mul_pkg::*;
(
  input  logic              mul_clk,
  input  logic              resetn,
  input  logic              mul,
  input  logic              mul_signed,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] result,
  output logic              complete,
  output logic              busy
);

  mul_state_e        r_state;
  mul_state_e        w_next_state;
  logic [PROD_W-1:0] r_mcand;
  logic [OP_W-1:0]   r_mplier;
  logic [PROD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign;
  logic [PROD_W-1:0] r_result;
  logic              r_complete;
  logic              r_busy;

  logic [OP_W-1:0]   w_x_abs;
  logic [OP_W-1:0]   w_y_abs;
  logic [PROD_W-1:0] w_acc_fix;
  logic [PROD_W-1:0] w_addend;
  logic              w_do_step;
  logic              w_mplier_zero;

  abs_conv #(.W(OP_W)) u_abs_x (
    .i_val (x),
    .i_neg (mul_signed & x[OP_W-1]),
    .o_val (w_x_abs)
  );

  abs_conv #(.W(OP_W)) u_abs_y (
    .i_val (y),
    .i_neg (mul_signed & y[OP_W-1]),
    .o_val (w_y_abs)
  );

  abs_conv #(.W(PROD_W)) u_fix (
    .i_val (r_acc),
    .i_neg (r_sign),
    .o_val (w_acc_fix)
  );

  assign w_mplier_zero = (r_mplier == {OP_W{1'b0}});

  // Step qualifier and partial product for the current RUN cycle.
  always_comb begin
    w_do_step = 1'b0;
    w_addend  = {PROD_W{1'b0}};
`ifdef MUL_EARLY_TERM_EN
    if ((r_state == ST_RUN) && !w_mplier_zero) begin
      w_do_step = 1'b1;
    end else begin
      w_do_step = 1'b0;
    end
`else
    if (r_state == ST_RUN) begin
      w_do_step = 1'b1;
    end else begin
      w_do_step = 1'b0;
    end
`endif
    if (r_mplier[0]) begin
      w_addend = r_mcand;
    end else begin
      w_addend = {PROD_W{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mul) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef MUL_EARLY_TERM_EN
        // A zero multiplier register means no partial products remain.
        if (w_mplier_zero || is_last_iter(r_cnt)) begin
          w_next_state = ST_FIX;
        end else begin
          w_next_state = ST_RUN;
        end
`else
        if (is_last_iter(r_cnt)) begin
          w_next_state = ST_FIX;
        end else begin
          w_next_state = ST_RUN;
        end
`endif
      end
      ST_FIX:  w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register with registered status outputs derived from next state.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state != ST_IDLE);
      r_complete <= (w_next_state == ST_DONE);
    end
  end

  // Datapath: operand capture, shift-add iterations and sign fix-up.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      r_mcand  <= {PROD_W{1'b0}};
      r_mplier <= {OP_W{1'b0}};
      r_acc    <= {PROD_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_sign   <= 1'b0;
      r_result <= {PROD_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mul) begin
            r_mcand  <= {{(PROD_W-OP_W){1'b0}}, w_x_abs};
            r_mplier <= w_y_abs;
            r_acc    <= {PROD_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_sign   <= mul_signed & (x[OP_W-1] ^ y[OP_W-1]);
          end
        end
        ST_RUN: begin
          if (w_do_step) begin
            r_acc    <= r_acc + w_addend;
            r_mcand  <= {r_mcand[PROD_W-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[OP_W-1:1]};
            r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          r_result <= w_acc_fix;
        end
        ST_DONE: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign result   = r_result;
  assign complete = r_complete;
  assign busy     = r_busy;

endmodule

// File: tb/tb_multiplier.sv
// ----------------------------------------------------------------------------
// tb_multiplier
// Directed self-checking bench for the iterative multiplier: reset state,
// signed/unsigned products, corner operands, latency, mid-run reset and
// back-to-back operation.
// ----------------------------------------------------------------------------
module tb_multiplier;

  logic        mul_clk;
  logic        resetn;
  logic        mul;
  logic        mul_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] result;
  logic        complete;
  logic        busy;

  int n_tests;
  int n_fail;

  multiplier dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .mul        (mul),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .result     (result),
    .complete   (complete),
    .busy       (busy)
  );

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  typedef struct {
    logic [31:0] vx;
    logic [31:0] vy;
    logic        vs;
    logic [63:0] vexp;
    int          lat_et;
  } vec_t;

  vec_t vecs[11];

  // Single comparison point: counts and reports mismatches.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input int lat_et);
`ifdef MUL_EARLY_TERM_EN
    return lat_et;
`else
    return 33 + 0 * lat_et;
`endif
  endfunction

  // One full operation; called with the DUT idle, #1 after a rising edge.
  task automatic run_op(input logic [31:0] ix, input logic [31:0] iy, input logic is,
                        input logic [63:0] exp, input int exp_lat, input string tag);
    logic [63:0] prev;
    int          n;
    bit          done;
    prev = result;
    x = ix; y = iy; mul_signed = is; mul = 1'b1;
    @(posedge mul_clk); #1;
    // Scramble inputs after accept: they must not influence the operation.
    mul = 1'b0; x = $urandom; y = $urandom; mul_signed = ~is;
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd1);
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(posedge mul_clk); #1;
      n++;
      if (n == 10 && exp_lat > 11) check_eq({tag, "_hold"}, result, prev);
      if (complete) done = 1'b1;
    end
    check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_eq({tag, "_res"}, result, exp);
    @(posedge mul_clk); #1;
    check_eq({tag, "_cpl1"}, {63'd0, complete}, 64'd0);
    check_eq({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int   n;
    int   idle_cnt;
    bit   saw_cpl;
    bit   done;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 33};
    vecs[1]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB, 5};
    vecs[2]  = '{32'hFFFFFFFD, 32'h00000007, 1'b0, 64'h00000006FFFFFFEB, 5};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 33};
    vecs[4]  = '{32'hFFFFFFFD, 32'hFFFFFFF9, 1'b1, 64'h0000000000000015, 5};
    vecs[5]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000, 33};
    vecs[6]  = '{32'h00000009, 32'h00000001, 1'b0, 64'h0000000000000009, 3};
    vecs[7]  = '{32'h12345678, 32'h00000000, 1'b0, 64'h0000000000000000, 2};
    vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 33};
    vecs[9]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3};
    vecs[10] = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 19};

    // Reset, with mul already high: it must not be accepted.
    resetn = 1'b0; mul = 1'b1; mul_signed = 1'b0; x = 32'd2; y = 32'd3;
    repeat (2) @(posedge mul_clk);
    #1;
    check_eq("rst_result",   result, 64'd0);
    check_eq("rst_complete", {63'd0, complete}, 64'd0);
    check_eq("rst_busy",     {63'd0, busy}, 64'd0);
    mul = 1'b0; resetn = 1'b1;
    @(posedge mul_clk); #1;
    check_eq("rst_no_accept", {63'd0, busy}, 64'd0);

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].vx, vecs[i].vy, vecs[i].vs, vecs[i].vexp,
             exp_latency(vecs[i].lat_et), $sformatf("vec%0d", i));
    end

    // Reset in the middle of RUN (counter at 10).
    x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; mul_signed = 1'b0; mul = 1'b1;
    @(posedge mul_clk); #1;
    mul = 1'b0;
    repeat (10) @(posedge mul_clk);
    #1;
    resetn = 1'b0;
    @(posedge mul_clk); #1;
    resetn = 1'b1;
    check_eq("abort_busy",   {63'd0, busy}, 64'd0);
    check_eq("abort_result", result, 64'd0);
    saw_cpl = (complete === 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(posedge mul_clk); #1;
      if (complete === 1'b1) saw_cpl = 1'b1;
    end
    check_eq("abort_no_cpl", {63'd0, saw_cpl}, 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 64'd6, exp_latency(4), "post_abort");

    // Back-to-back with mul held high.
    x = 32'd5; y = 32'd6; mul_signed = 1'b0; mul = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(posedge mul_clk); #1;
      n++;
      if (complete) done = 1'b1;
    end
    check_eq("b2b_first_lat", 64'(n), 64'(exp_latency(5) + 1));
    check_eq("b2b_first_res", result, 64'd30);
    x = 32'd7; y = 32'd8;
    idle_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge mul_clk); #1;
      if (busy == 1'b0) idle_cnt++;
      if (busy == 1'b1 && idle_cnt > 0) break;
    end
    check_eq("b2b_idle_gap", 64'(idle_cnt), 64'd1);
    mul = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 100) begin
      @(posedge mul_clk); #1;
      n++;
      if (complete) done = 1'b1;
    end
    check_eq("b2b_second_lat", 64'(n), 64'(exp_latency(6)));
    check_eq("b2b_second_res", result, 64'd56);
    @(posedge mul_clk); #1;
    check_eq("b2b_end_idle", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
